// File: rtl/brush_stamp_ctrl.sv
// Write-port sequencer for the canvas store: expands clipped square stamps and
// full-canvas clear fills into one pixel write per clock.
module brush_stamp_ctrl #(
  parameter int unsigned CANVAS_W = 201,
  parameter int unsigned CANVAS_H = 201
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stamp_req,
  input  logic [7:0] cx,
  input  logic [7:0] cy,
  input  logic [2:0] radius,
  input  logic [2:0] color,
  input  logic       clear_req,
  input  logic [2:0] clear_color,
  output logic       brush,
  output logic [7:0] wx,
  output logic [7:0] wy,
  output logic [2:0] newColor,
  output logic       busy,
  output logic       done
);

  localparam logic signed [9:0] XLast  = signed'(10'(CANVAS_W - 1));
  localparam logic signed [9:0] YLast  = signed'(10'(CANVAS_H - 1));
  localparam logic [7:0]        XLast8 = 8'(CANVAS_W - 1);
  localparam logic [7:0]        YLast8 = 8'(CANVAS_H - 1);

  typedef enum logic [1:0] {StIdle, StStamp, StClear} state_e;

  state_e     state_q, state_d;
  logic [7:0] wx_q, wx_d, wy_q, wy_d;
  logic [2:0] col_q, col_d;
  logic       brush_q, brush_d, busy_q, busy_d, done_q, done_d;
  logic [7:0] x0_q, x0_d, x1_q, x1_d, y1_q, y1_d;
  logic       pend_q, pend_d;
  logic [2:0] pend_col_q, pend_col_d;

  // Clipped stamp bounds; signed so cx-r below zero clamps rather than wraps.
  logic signed [9:0] cx_s, cy_s, r_s, xlo, xhi, ylo, yhi;
  logic signed [9:0] x0_c, x1_c, y0_c, y1_c;
  logic              empty_c;

  always_comb begin
    cx_s    = signed'({2'b00, cx});
    cy_s    = signed'({2'b00, cy});
    r_s     = signed'({7'd0, radius});
    xlo     = cx_s - r_s;
    xhi     = cx_s + r_s;
    ylo     = cy_s - r_s;
    yhi     = cy_s + r_s;
    x0_c    = (xlo < 10'sd0) ? 10'sd0 : xlo;
    y0_c    = (ylo < 10'sd0) ? 10'sd0 : ylo;
    x1_c    = (xhi > XLast) ? XLast : xhi;
    y1_c    = (yhi > YLast) ? YLast : yhi;
    empty_c = (x0_c > x1_c) || (y0_c > y1_c);
  end

  always_comb begin
    state_d    = state_q;
    wx_d       = wx_q;
    wy_d       = wy_q;
    col_d      = col_q;
    brush_d    = brush_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    x0_d       = x0_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    pend_d     = pend_q;
    pend_col_d = pend_col_q;

    unique case (state_q)
      StIdle: begin
        brush_d = 1'b0;
        busy_d  = 1'b0;
        if (pend_q || clear_req) begin
          state_d = StClear;
          brush_d = 1'b1;
          busy_d  = 1'b1;
          wx_d    = 8'd0;
          wy_d    = 8'd0;
          col_d   = pend_q ? pend_col_q : clear_color;
          pend_d  = 1'b0;
        end else if (stamp_req) begin
          if (empty_c) begin
            done_d = 1'b1;
          end else begin
            state_d = StStamp;
            brush_d = 1'b1;
            busy_d  = 1'b1;
            wx_d    = x0_c[7:0];
            wy_d    = y0_c[7:0];
            col_d   = color;
            x0_d    = x0_c[7:0];
            x1_d    = x1_c[7:0];
            y1_d    = y1_c[7:0];
          end
        end
      end
      StStamp: begin
        if (clear_req) begin
          pend_d     = 1'b1;
          pend_col_d = clear_color;
        end
        if (wx_q == x1_q) begin
          if (wy_q == y1_q) begin
            state_d = StIdle;
            brush_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            wx_d = x0_q;
            wy_d = wy_q + 8'd1;
          end
        end else begin
          wx_d = wx_q + 8'd1;
        end
      end
      StClear: begin
        if (wx_q == XLast8) begin
          if (wy_q == YLast8) begin
            state_d = StIdle;
            brush_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            wx_d = 8'd0;
            wy_d = wy_q + 8'd1;
          end
        end else begin
          wx_d = wx_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wx_q       <= 8'd0;
      wy_q       <= 8'd0;
      col_q      <= 3'd0;
      brush_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      x0_q       <= 8'd0;
      x1_q       <= 8'd0;
      y1_q       <= 8'd0;
      pend_q     <= 1'b0;
      pend_col_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      wx_q       <= wx_d;
      wy_q       <= wy_d;
      col_q      <= col_d;
      brush_q    <= brush_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      pend_q     <= pend_d;
      pend_col_q <= pend_col_d;
    end
  end

  assign brush    = brush_q;
  assign wx       = wx_q;
  assign wy       = wy_q;
  assign newColor = col_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_brush_stamp_ctrl.sv
// Bench for brush_stamp_ctrl: stamp vector table plus clear, arbitration,
// pending-clear and reset-abort sequences, checked against a write scoreboard.
`timescale 1ns/1ps
module tb_brush_stamp_ctrl;

  localparam int W = 201;
  localparam int H = 201;

  logic       clk = 1'b0;
  logic       reset;
  logic       stamp_req;
  logic [7:0] cx, cy;
  logic [2:0] radius, color;
  logic       clear_req;
  logic [2:0] clear_color;
  logic       brush, busy, done;
  logic [7:0] wx, wy;
  logic [2:0] newColor;

  brush_stamp_ctrl #(.CANVAS_W(W), .CANVAS_H(H)) dut (
    .clk(clk), .reset(reset), .stamp_req(stamp_req), .cx(cx), .cy(cy), .radius(radius),
    .color(color), .clear_req(clear_req), .clear_color(clear_color), .brush(brush),
    .wx(wx), .wy(wy), .newColor(newColor), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {logic [7:0] x; logic [7:0] y; logic [2:0] c;} wr_t;
  wr_t exp_q[$];

  typedef struct {int cx; int cy; int r; int col; int k; int fx; int fy; int lx; int ly;} vec_t;
  vec_t vecs[8];

  int n_pass = 0;
  int n_total = 0;
  int wcount, first_cyc, first_x, first_y, last_x, last_y;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  task automatic push_stamp(input int pcx, input int pcy, input int r, input int col);
    int x0, x1, y0, y1;
    x0 = (pcx - r < 0) ? 0 : pcx - r;
    y0 = (pcy - r < 0) ? 0 : pcy - r;
    x1 = (pcx + r > W - 1) ? W - 1 : pcx + r;
    y1 = (pcy + r > H - 1) ? H - 1 : pcy + r;
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        exp_q.push_back('{x: 8'(x), y: 8'(y), c: 3'(col)});
  endtask

  task automatic push_clear(input int col, input int limit);
    int n;
    n = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (n < limit) begin
          exp_q.push_back('{x: 8'(x), y: 8'(y), c: 3'(col)});
          n++;
        end
  endtask

  task automatic clear_stats();
    wcount = 0; first_cyc = -1; first_x = -1; first_y = -1; last_x = -1; last_y = -1;
  endtask

  // Scoreboard: every brush cycle pops one expected write.
  always @(negedge clk) begin
    wr_t e;
    check("busy_vs_brush", 32'(busy), 32'(brush));
    if (brush === 1'b1) begin
      if (wcount == 0) begin first_cyc = cyc; first_x = wx; first_y = wy; end
      last_x = wx; last_y = wy;
      wcount++;
      if (exp_q.size() == 0) check("unexpected_write", 32'({wx, wy, newColor}), -1);
      else begin
        e = exp_q.pop_front();
        check("write_xyc", 32'({wx, wy, newColor}), 32'(e));
      end
    end
  end

  task automatic wait_done(input int budget, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin dcyc = cyc; break; end
    end
    if (dcyc < 0) check("done_timeout", 0, 1);
  endtask

  task automatic run_vec(input int i);
    int n, dc;
    clear_stats();
    @(posedge clk); #1;
    cx = 8'(vecs[i].cx); cy = 8'(vecs[i].cy);
    radius = 3'(vecs[i].r); color = 3'(vecs[i].col);
    stamp_req = 1'b1;
    push_stamp(vecs[i].cx, vecs[i].cy, vecs[i].r, vecs[i].col);
    @(posedge clk); #1;
    n = cyc;
    stamp_req = 1'b0;
    cx = cx + 8'd37; cy = cy + 8'd11; color = ~color; radius = ~radius;
    wait_done(vecs[i].k + 20, dc);
    check("done_cycle", dc, n + vecs[i].k);
    check("write_count", wcount, vecs[i].k);
    if (vecs[i].k > 0) begin
      check("first_cycle", first_cyc, n);
      check("first_x", first_x, vecs[i].fx);
      check("first_y", first_y, vecs[i].fy);
      check("last_x", last_x, vecs[i].lx);
      check("last_y", last_y, vecs[i].ly);
    end
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, d1, d2, d3;
    vecs[0] = '{100, 50, 1, 5, 9, 99, 49, 101, 51};
    vecs[1] = '{0, 0, 2, 1, 9, 0, 0, 2, 2};
    vecs[2] = '{200, 200, 3, 6, 16, 197, 197, 200, 200};
    vecs[3] = '{230, 10, 1, 4, 0, 0, 0, 0, 0};
    vecs[4] = '{7, 9, 0, 7, 1, 7, 9, 7, 9};
    vecs[5] = '{5, 3, 7, 2, 143, 0, 0, 12, 10};
    vecs[6] = '{255, 255, 2, 3, 0, 0, 0, 0, 0};
    vecs[7] = '{100, 200, 4, 3, 45, 96, 196, 104, 200};

    reset = 1'b1; stamp_req = 1'b0; clear_req = 1'b0;
    cx = 8'd0; cy = 8'd0; radius = 3'd0; color = 3'd0; clear_color = 3'd0;
    clear_stats();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_brush", 32'(brush), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_wx", 32'(wx), 0);
    check("rst_wy", 32'(wy), 0);
    check("rst_color", 32'(newColor), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i);

    // Simultaneous clear and stamp: clear wins, stamp dropped.
    clear_stats();
    @(posedge clk); #1;
    cx = 8'd40; cy = 8'd40; radius = 3'd1; color = 3'd7; stamp_req = 1'b1;
    clear_req = 1'b1; clear_color = 3'd2;
    push_clear(2, W * H);
    @(posedge clk); #1;
    n = cyc;
    stamp_req = 1'b0; clear_req = 1'b0; clear_color = 3'd6;
    wait_done(W * H + 20, d1);
    check("arb_done_cycle", d1, n + W * H);
    check("arb_writes", wcount, W * H);
    check("arb_last_x", last_x, 200);
    check("arb_last_y", last_y, 200);
    repeat (5) @(negedge clk);
    check("arb_stamp_dropped", wcount, W * H);

    // Pending clear during a stamp, with a stamp request held high throughout.
    clear_stats();
    @(posedge clk); #1;
    cx = 8'd50; cy = 8'd60; radius = 3'd2; color = 3'd1; stamp_req = 1'b1;
    push_stamp(50, 60, 2, 1);
    @(posedge clk); #1;
    n = cyc;
    cx = 8'd20; cy = 8'd30; radius = 3'd1; color = 3'd6;
    repeat (10) begin @(posedge clk); #1; end
    clear_req = 1'b1; clear_color = 3'd3;
    push_clear(3, W * H);
    push_stamp(20, 30, 1, 6);
    @(posedge clk); #1;
    clear_req = 1'b0; clear_color = 3'd5;
    wait_done(60, d1);
    check("pend_stamp_done", d1, n + 25);
    wait_done(W * H + 20, d2);
    check("pend_clear_done", d2, d1 + 1 + W * H);
    wait_done(60, d3);
    stamp_req = 1'b0;
    check("pend_stamp2_done", d3, d2 + 1 + 9);
    repeat (5) @(negedge clk);
    check("pend_total_writes", wcount, 25 + W * H + 9);
    check("pend_queue_drained", exp_q.size(), 0);

    // Reset aborts a clear at write 1000.
    clear_stats();
    @(posedge clk); #1;
    clear_req = 1'b1; clear_color = 3'd4;
    push_clear(4, 1000);
    @(posedge clk); #1;
    clear_req = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (wcount >= 1000) break;
    end
    reset = 1'b1;
    @(negedge clk);
    check("abort_brush", 32'(brush), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_wx", 32'(wx), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 0);
    end
    check("abort_writes", wcount, 1000);
    check("abort_queue", exp_q.size(), 0);
    run_vec(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
